// File: rtl/ptw_req_arbiter.sv
// Two-requestor front end for a single page-table walker: picks one request,
// issues it to the walker, and routes the PTE back to the requestor that asked.
module ptw_req_arbiter (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        io_requestor_0_req_valid,
  output logic        io_requestor_0_req_ready,
  input  logic [26:0] io_requestor_0_req_addr,
  input  logic [1:0]  io_requestor_0_req_prv,
  input  logic        io_requestor_0_req_store,
  input  logic        io_requestor_0_req_fetch,
  output logic        io_requestor_0_resp_valid,
  output logic [37:0] io_requestor_0_resp_pte_ppn,
  output logic [7:0]  io_requestor_0_resp_pte_perm,

  input  logic        io_requestor_1_req_valid,
  output logic        io_requestor_1_req_ready,
  input  logic [26:0] io_requestor_1_req_addr,
  input  logic [1:0]  io_requestor_1_req_prv,
  input  logic        io_requestor_1_req_store,
  input  logic        io_requestor_1_req_fetch,
  output logic        io_requestor_1_resp_valid,
  output logic [37:0] io_requestor_1_resp_pte_ppn,
  output logic [7:0]  io_requestor_1_resp_pte_perm,

  output logic        io_ptw_req_valid,
  input  logic        io_ptw_req_ready,
  output logic [26:0] io_ptw_req_addr,
  output logic [1:0]  io_ptw_req_prv,
  output logic        io_ptw_req_store,
  output logic        io_ptw_req_fetch,

  input  logic        io_ptw_resp_valid,
  input  logic [37:0] io_ptw_resp_pte_ppn,
  input  logic [7:0]  io_ptw_resp_pte_perm,
  input  logic        io_dpath_invalidate,
  output logic        io_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        kill_q, kill_d;
  logic        owner_q, owner_d;
  logic [26:0] addr_q, addr_d;
  logic [1:0]  prv_q, prv_d;
  logic        store_q, store_d;
  logic        fetch_q, fetch_d;
  logic [37:0] ppn_q, ppn_d;
  logic [7:0]  perm_q, perm_d;

  logic any_valid;
  logic sel;
  logic handshake;

  // Selection: a lone requestor wins outright; a tie goes to the rr pointer.
  always_comb begin
    any_valid = io_requestor_0_req_valid | io_requestor_1_req_valid;
    if (io_requestor_0_req_valid && !io_requestor_1_req_valid) begin
      sel = 1'b0;
    end else if (io_requestor_1_req_valid && !io_requestor_0_req_valid) begin
      sel = 1'b1;
    end else begin
      sel = rr_q;
    end
    handshake = (state_q == IDLE) && any_valid;
  end

  assign io_requestor_0_req_ready = (state_q == IDLE) && any_valid && !sel;
  assign io_requestor_1_req_ready = (state_q == IDLE) && any_valid &&  sel;

  assign io_ptw_req_valid = (state_q == ISSUE);
  assign io_ptw_req_addr  = addr_q;
  assign io_ptw_req_prv   = prv_q;
  assign io_ptw_req_store = store_q;
  assign io_ptw_req_fetch = fetch_q;

  assign io_requestor_0_resp_valid    = (state_q == RESP) && !owner_q;
  assign io_requestor_1_resp_valid    = (state_q == RESP) &&  owner_q;
  assign io_requestor_0_resp_pte_ppn  = ppn_q;
  assign io_requestor_0_resp_pte_perm = perm_q;
  assign io_requestor_1_resp_pte_ppn  = ppn_q;
  assign io_requestor_1_resp_pte_perm = perm_q;

  assign io_busy = (state_q != IDLE);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    rr_d    = rr_q;
    kill_d  = kill_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    prv_d   = prv_q;
    store_d = store_q;
    fetch_d = fetch_q;
    ppn_d   = ppn_q;
    perm_d  = perm_q;

    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          owner_d = sel;
          rr_d    = ~sel;
          addr_d  = sel ? io_requestor_1_req_addr  : io_requestor_0_req_addr;
          prv_d   = sel ? io_requestor_1_req_prv   : io_requestor_0_req_prv;
          store_d = sel ? io_requestor_1_req_store : io_requestor_0_req_store;
          fetch_d = sel ? io_requestor_1_req_fetch : io_requestor_0_req_fetch;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (io_dpath_invalidate) kill_d = 1'b1;
        if (io_ptw_req_ready)    state_d = WAIT;
      end
      WAIT: begin
        if (io_dpath_invalidate) kill_d = 1'b1;
        if (io_ptw_resp_valid) begin
          // A same-cycle invalidate kills this response too.
          if (kill_q || io_dpath_invalidate) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ppn_d   = io_ptw_resp_pte_ppn;
            perm_d  = io_ptw_resp_pte_perm;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      kill_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      kill_q  <= kill_d;
      owner_q <= owner_d;
    end
  end

  // NOTE: the captured request/response fields are reset as well because they
  // drive output ports directly and must read as zero while in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      prv_q   <= '0;
      store_q <= 1'b0;
      fetch_q <= 1'b0;
      ppn_q   <= '0;
      perm_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      prv_q   <= prv_d;
      store_q <= store_d;
      fetch_q <= fetch_d;
      ppn_q   <= ppn_d;
      perm_q  <= perm_d;
    end
  end

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Directed and randomized walks against a transaction-level model of the
// arbiter: who wins, what reaches the walker, and which response comes back.
module tb_ptw_req_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        r_valid [2];
  logic        r_ready [2];
  logic [26:0] r_addr  [2];
  logic [1:0]  r_prv   [2];
  logic        r_store [2];
  logic        r_fetch [2];
  logic        rs_valid[2];
  logic [37:0] rs_ppn  [2];
  logic [7:0]  rs_perm [2];

  logic        ptw_req_valid, ptw_req_ready;
  logic [26:0] ptw_req_addr;
  logic [1:0]  ptw_req_prv;
  logic        ptw_req_store, ptw_req_fetch;
  logic        ptw_resp_valid;
  logic [37:0] ptw_resp_ppn;
  logic [7:0]  ptw_resp_perm;
  logic        invalidate;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int model_rr = 0;

  always #5 clock = ~clock;

  ptw_req_arbiter dut (
    .clock                        (clock),
    .reset_n                      (reset_n),
    .io_requestor_0_req_valid     (r_valid[0]),
    .io_requestor_0_req_ready     (r_ready[0]),
    .io_requestor_0_req_addr      (r_addr[0]),
    .io_requestor_0_req_prv       (r_prv[0]),
    .io_requestor_0_req_store     (r_store[0]),
    .io_requestor_0_req_fetch     (r_fetch[0]),
    .io_requestor_0_resp_valid    (rs_valid[0]),
    .io_requestor_0_resp_pte_ppn  (rs_ppn[0]),
    .io_requestor_0_resp_pte_perm (rs_perm[0]),
    .io_requestor_1_req_valid     (r_valid[1]),
    .io_requestor_1_req_ready     (r_ready[1]),
    .io_requestor_1_req_addr      (r_addr[1]),
    .io_requestor_1_req_prv       (r_prv[1]),
    .io_requestor_1_req_store     (r_store[1]),
    .io_requestor_1_req_fetch     (r_fetch[1]),
    .io_requestor_1_resp_valid    (rs_valid[1]),
    .io_requestor_1_resp_pte_ppn  (rs_ppn[1]),
    .io_requestor_1_resp_pte_perm (rs_perm[1]),
    .io_ptw_req_valid             (ptw_req_valid),
    .io_ptw_req_ready             (ptw_req_ready),
    .io_ptw_req_addr              (ptw_req_addr),
    .io_ptw_req_prv               (ptw_req_prv),
    .io_ptw_req_store             (ptw_req_store),
    .io_ptw_req_fetch             (ptw_req_fetch),
    .io_ptw_resp_valid            (ptw_resp_valid),
    .io_ptw_resp_pte_ppn          (ptw_resp_ppn),
    .io_ptw_resp_pte_perm         (ptw_resp_perm),
    .io_dpath_invalidate          (invalidate),
    .io_busy                      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_req(input int n);
    r_addr[n]  = 27'($urandom());
    r_prv[n]   = 2'($urandom_range(0, 3));
    r_store[n] = 1'($urandom_range(0, 1));
    r_fetch[n] = 1'($urandom_range(0, 1));
  endtask

  task automatic quiet_inputs();
    r_valid[0]     = 1'b0;
    r_valid[1]     = 1'b0;
    ptw_req_ready  = 1'b0;
    ptw_resp_valid = 1'b0;
    ptw_resp_ppn   = '0;
    ptw_resp_perm  = '0;
    invalidate     = 1'b0;
  endtask

  task automatic apply_reset();
    quiet_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n  = 1'b1;
    model_rr = 0;
  endtask

  // One full walk from IDLE. inv_at: -1 none, 0 in ISSUE, 1 first WAIT cycle,
  // 2 together with the walker response.
  task automatic do_walk(input bit v0, input bit v1, input int stall, input int lat,
                         input int inv_at, input logic [37:0] ppn, input logic [7:0] perm,
                         input bit spur);
    int          own;
    logic [26:0] e_addr;
    logic [1:0]  e_prv;
    logic        e_store, e_fetch;
    bit          killed;

    own      = (v0 && !v1) ? 0 : (v1 && !v0) ? 1 : model_rr;
    model_rr = 1 - own;
    e_addr   = r_addr[own];
    e_prv    = r_prv[own];
    e_store  = r_store[own];
    e_fetch  = r_fetch[own];

    r_valid[0]     = v0;
    r_valid[1]     = v1;
    ptw_req_ready  = 1'($urandom_range(0, 1));
    ptw_resp_valid = spur | 1'($urandom_range(0, 1));
    invalidate     = 1'($urandom_range(0, 1));
    @(negedge clock);
    check("idle_ready0", 64'(r_ready[0]), 64'(own == 0));
    check("idle_ready1", 64'(r_ready[1]), 64'(own == 1));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_ptw_valid", 64'(ptw_req_valid), 64'(0));
    check("idle_resp0", 64'(rs_valid[0]), 64'(0));
    check("idle_resp1", 64'(rs_valid[1]), 64'(0));
    tick();

    r_valid[own]   = 1'b0;
    randomize_req(own);
    ptw_resp_valid = 1'b0;
    invalidate     = 1'b0;

    for (int s = 0; s <= stall; s++) begin
      ptw_req_ready  = (s == stall);
      invalidate     = (inv_at == 0) && (s == 0);
      ptw_resp_valid = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("issue_valid", 64'(ptw_req_valid), 64'(1));
      check("issue_addr", 64'(ptw_req_addr), 64'(e_addr));
      check("issue_attr", 64'({ptw_req_prv, ptw_req_store, ptw_req_fetch}),
            64'({e_prv, e_store, e_fetch}));
      check("issue_ready_both", 64'({r_ready[1], r_ready[0]}), 64'(0));
      check("issue_busy", 64'(busy), 64'(1));
      check("issue_resp", 64'({rs_valid[1], rs_valid[0]}), 64'(0));
      tick();
    end

    for (int w = 0; w <= lat; w++) begin
      ptw_req_ready  = 1'($urandom_range(0, 1));
      ptw_resp_valid = (w == lat);
      ptw_resp_ppn   = (w == lat) ? ppn  : 38'({$urandom(), $urandom()});
      ptw_resp_perm  = (w == lat) ? perm : 8'($urandom());
      invalidate     = ((inv_at == 1) && (w == 0)) || ((inv_at == 2) && (w == lat));
      @(negedge clock);
      check("wait_ptw_valid", 64'(ptw_req_valid), 64'(0));
      check("wait_busy", 64'(busy), 64'(1));
      check("wait_resp", 64'({rs_valid[1], rs_valid[0]}), 64'(0));
      check("wait_ready_both", 64'({r_ready[1], r_ready[0]}), 64'(0));
      tick();
    end

    killed         = (inv_at >= 0);
    ptw_resp_valid = 1'($urandom_range(0, 1));
    ptw_resp_ppn   = 38'({$urandom(), $urandom()});
    ptw_resp_perm  = 8'($urandom());
    ptw_req_ready  = 1'b0;
    if (!killed) begin
      invalidate = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("resp_owner_valid", 64'(rs_valid[own]), 64'(1));
      check("resp_other_valid", 64'(rs_valid[1-own]), 64'(0));
      check("resp_ppn", 64'(rs_ppn[own]), 64'(ppn));
      check("resp_perm", 64'(rs_perm[own]), 64'(perm));
      check("resp_busy", 64'(busy), 64'(1));
      tick();
    end
    ptw_resp_valid = 1'b0;
    invalidate     = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    quiet_inputs();
    for (int n = 0; n < 2; n++) begin
      r_addr[n] = '0; r_prv[n] = '0; r_store[n] = 1'b0; r_fetch[n] = 1'b0;
    end
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'({r_ready[1], r_ready[0]}), 64'(0));
    check("rst_ptw_valid", 64'(ptw_req_valid), 64'(0));
    check("rst_ptw_addr", 64'(ptw_req_addr), 64'(0));
    apply_reset();

    // Single request from requestor 0, response three cycles later.
    r_addr[0] = 27'h1234567; r_prv[0] = 2'd1; r_store[0] = 1'b0; r_fetch[0] = 1'b1;
    do_walk(1, 0, 0, 3, -1, 38'hABCDE, 8'hCF, 0);

    // Simultaneous requests right after reset: 0 first, then the pending 1.
    apply_reset();
    randomize_req(0); randomize_req(1);
    do_walk(1, 1, 0, 1, -1, 38'h1111, 8'h01, 0);
    do_walk(0, 1, 0, 2, -1, 38'h2222, 8'h02, 0);

    // Fairness with both requestors always valid.
    for (int k = 0; k < 4; k++) begin
      randomize_req(0); randomize_req(1);
      do_walk(1, 1, 0, 0, -1, 38'(k + 38'h3000), 8'(k + 8'h10), 0);
    end

    // Walker back-pressure in ISSUE for five cycles.
    randomize_req(0);
    do_walk(1, 0, 5, 2, -1, 38'h3FFFFFFFFF, 8'hFF, 0);

    // Invalidates in WAIT, ISSUE and coincident with the response, then a normal walk.
    randomize_req(0);
    do_walk(1, 0, 0, 2, 1, 38'h4444, 8'h44, 0);
    randomize_req(1);
    do_walk(0, 1, 0, 1, -1, 38'h5555, 8'h55, 0);
    do_walk(0, 1, 2, 1, 0, 38'h6666, 8'h66, 0);
    do_walk(1, 0, 0, 3, 2, 38'h7777, 8'h77, 0);
    do_walk(1, 0, 0, 0, -1, 38'h8888, 8'h88, 0);

    // Reset while the walker owns a request, then a late walker response.
    randomize_req(1);
    r_valid[1] = 1'b1;
    tick();
    r_valid[1]    = 1'b0;
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    @(negedge clock);
    check("mid_walk_busy", 64'(busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_ptw_valid", 64'(ptw_req_valid), 64'(0));
    check("mrst_ready", 64'({r_ready[1], r_ready[0]}), 64'(0));
    check("mrst_resp", 64'({rs_valid[1], rs_valid[0]}), 64'(0));
    check("mrst_ptw_addr", 64'(ptw_req_addr), 64'(0));
    check("mrst_ppn", 64'(rs_ppn[1]), 64'(0));
    tick();
    reset_n  = 1'b1;
    model_rr = 0;
    randomize_req(0);
    do_walk(1, 0, 0, 1, -1, 38'h9999, 8'h99, 1);

    // Randomized walks.
    for (int k = 0; k < 40; k++) begin
      int v;
      int inv;
      v   = $urandom_range(1, 3);
      inv = $urandom_range(0, 5);
      randomize_req(0); randomize_req(1);
      do_walk(v[0], v[1], $urandom_range(0, 3), $urandom_range(0, 4),
              (inv > 2) ? -1 : inv, 38'({$urandom(), $urandom()}), 8'($urandom()), 0);
    end

    @(negedge clock);
    check("final_busy", 64'(busy), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ptw_req_arbiter.md
PTW_REQ_ARBITER -- requirements
Module: ptw_req_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports "clock" (input, 1, rising-edge clock) and "reset_n" (input, 1, async active-low reset).
REQ-002 For each requestor N = 0 and 1, the block SHALL have these ports:
- io_requestor_N_req_valid, input, 1: request present.
- io_requestor_N_req_ready, output, 1: arbiter accepts the request.
- io_requestor_N_req_addr, input, 27: VPN to walk.
- io_requestor_N_req_prv, input, 2: privilege level of the request.
- io_requestor_N_req_store, input, 1: request is a store.
- io_requestor_N_req_fetch, input, 1: request is an instruction fetch.
REQ-003 For each requestor N, the block SHALL have these response ports:
- io_requestor_N_resp_valid, output, 1: one-cycle response pulse.
- io_requestor_N_resp_pte_ppn, output, 38: PPN of the returned PTE.
- io_requestor_N_resp_pte_perm, output, 8: PTE flags {d,a,g,u,x,w,r,v}.
REQ-004 The walker-side request ports SHALL be:
- io_ptw_req_valid, output, 1.
- io_ptw_req_ready, input, 1.
- io_ptw_req_addr, output, 27.
- io_ptw_req_prv, output, 2.
- io_ptw_req_store, output, 1.
- io_ptw_req_fetch, output, 1.
REQ-005 The walker-side response and control ports SHALL be:
- io_ptw_resp_valid, input, 1.
- io_ptw_resp_pte_ppn, input, 38.
- io_ptw_resp_pte_perm, input, 8.
- io_dpath_invalidate, input, 1: TLB/PTW flush pulse.
- io_busy, output, 1: high in every state except IDLE.

Function
REQ-006 The block SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-007 In IDLE, io_requestor_N_req_ready SHALL be 1 only for the selected requestor, and 0 for both requestors in all other states.
REQ-008 The selection rule in IDLE SHALL be: if exactly one requestor is valid, select it; if both are valid, select the requestor indicated by the 1-bit round-robin pointer rr.
REQ-009 On a handshake (valid and ready both 1), the block SHALL register addr, prv, store, fetch and the owner id, and go to ISSUE on the next cycle.
REQ-010 On each accepted handshake, rr SHALL be set to the requestor that was not granted.
REQ-011 In ISSUE, io_ptw_req_valid SHALL be 1 and the io_ptw_req_* bits SHALL equal the registered fields.
REQ-012 The ISSUE request fields SHALL stay stable until io_ptw_req_ready is 1.
REQ-013 When io_ptw_req_ready is 1 in ISSUE, the FSM SHALL go to WAIT; io_ptw_req_valid SHALL be 0 outside ISSUE.
REQ-014 In WAIT, when io_ptw_resp_valid is 1, the block SHALL register ppn and perm and go to RESP.
REQ-015 In RESP, io_requestor_<owner>_resp_valid SHALL be 1 for exactly one cycle, carrying the registered ppn and perm.
REQ-016 In RESP, the non-owner requestor's resp_valid SHALL be 0, and the FSM SHALL go to IDLE.
REQ-017 Latency from request handshake to the first io_ptw_req_valid SHALL be 1 cycle.
REQ-018 Latency from io_ptw_resp_valid to io_requestor_N_resp_valid SHALL be 1 cycle.
REQ-019 io_ptw_resp_valid SHALL be ignored in IDLE, ISSUE and RESP.
REQ-020 Invalidate in IDLE: io_dpath_invalidate SHALL have no effect.
REQ-021 Invalidate in ISSUE: the block SHALL complete the issue handshake and set a kill flag.
REQ-022 Invalidate in WAIT: the block SHALL set the kill flag.
REQ-023 Invalidate in the same cycle as io_ptw_resp_valid in WAIT: the kill flag SHALL take effect for that response.
REQ-024 With the kill flag set, the walker response SHALL still be consumed, but no resp_valid SHALL be asserted. The FSM SHALL go WAIT to IDLE directly and clear the kill flag.
REQ-025 Invalidate in RESP: the response SHALL still be delivered.
REQ-026 Between IDLE and IDLE, at most one walk SHALL be outstanding; new requests SHALL be back-pressured while busy.
REQ-027 The resp_pte_* outputs SHALL be the registered values at all times; they are don't-care when resp_valid is 0.

Reset
REQ-028 While reset_n is 0, the FSM SHALL be IDLE, rr SHALL be 0 and the kill flag SHALL be 0.
REQ-029 While reset_n is 0, all valid/ready outputs and io_busy SHALL be 0, and all data registers SHALL be 0.
REQ-030 A reset asserted mid-walk SHALL abandon the walk with no resp_valid pulse, and the block SHALL accept a new request on the first cycle after reset deassertion.

Verification
REQ-031 The bench SHALL cover a single request: req0 valid, addr=0x1234567; ptw_req_ready=1; resp after 3 cycles with ppn=0xABCDE and perm=0xCF -> ptw_req_valid 1 cycle after the handshake; requestor_0 resp_valid 1 cycle after ptw resp with ppn=0xABCDE and perm=0xCF; requestor_1 never valid.
REQ-032 The bench SHALL cover simultaneous requests: req0 and req1 valid in IDLE after reset -> req0 granted first (rr=0), req1 granted on the next IDLE; responses are routed to 0 then 1.
REQ-033 The bench SHALL cover fairness: req0 continuously valid and req1 valid -> grants alternate 0,1,0,1 over 4 walks.
REQ-034 The bench SHALL cover back-pressure: ptw_req_ready held 0 for 5 cycles in ISSUE -> ptw_req_valid and its fields stay stable, both req_ready stay 0, and io_busy=1.
REQ-035 The bench SHALL cover invalidate in WAIT: invalidate pulse in WAIT, then ptw resp -> no requestor resp_valid and the FSM returns to IDLE; a following req1 is served normally.
REQ-036 The bench SHALL cover reset mid-walk: reset_n pulsed low in WAIT -> all outputs 0 immediately, and a late ptw resp after reset produces no resp_valid.
